// File: rtl/p4_router_pkg.sv
// Shared P4 router definitions: RTL egress/ingress port IDs, the VNP4 user
// metadata layout and the egress drop sentinel.
package p4_router_pkg;

    localparam logic [7:0] EGR_ID_CPU   = 8'd0;
    localparam logic [7:0] EGR_ID_OISL0 = 8'd1;
    localparam logic [7:0] EGR_ID_OISL1 = 8'd2;
    localparam logic [7:0] EGR_ID_ECP0  = 8'd3;
    localparam logic [7:0] EGR_ID_ECP1  = 8'd4;
    localparam logic [7:0] EGR_ID_HDR0  = 8'd5;
    localparam logic [7:0] EGR_ID_HDR1  = 8'd6;
    localparam logic [7:0] EGR_ID_ECG0  = 8'd7;
    localparam logic [7:0] EGR_ID_ECG1  = 8'd8;
    localparam logic [7:0] EGR_ID_ECG2  = 8'd9;
    localparam logic [7:0] EGR_ID_ECG3  = 8'd10;

    localparam logic [7:0] ING_ID_CPU   = 8'd0;
    localparam logic [7:0] ING_ID_OISL0 = 8'd1;
    localparam logic [7:0] ING_ID_OISL1 = 8'd2;
    localparam logic [7:0] ING_ID_ECP0  = 8'd3;
    localparam logic [7:0] ING_ID_ECP1  = 8'd4;

    // egr_spec value the pipeline uses to mean "discard this packet"
    localparam logic [7:0] EGR_DROP_SENTINEL = 8'hFF;

    typedef struct packed {
        logic [7:0] egr_spec;
        logic [7:0] ing_port;
    } USER_META_DATA_METADATA_T;

endpackage

// File: rtl/p4_router_egress_demux_if.sv
// Stream bundle around the egress demux: VNP4 input side, per-port egress side
// and the per-packet metadata strobe. 'master' is the demux view.
interface p4_router_egress_demux_if #(
    parameter int DATA_BYTES        = 8,
    parameter int NUM_EGR_PORTS     = 11,
    parameter int EGR_SPEC_ID_WIDTH = 8,
    parameter int ING_PORT_ID_WIDTH = 8
);
    logic [DATA_BYTES*8-1:0]                         s_axis_tdata;
    logic [DATA_BYTES-1:0]                           s_axis_tkeep;
    logic                                            s_axis_tlast;
    logic                                            s_axis_tvalid;
    logic                                            s_axis_tready;
    logic [EGR_SPEC_ID_WIDTH+ING_PORT_ID_WIDTH-1:0]  user_metadata_in;
    logic                                            user_metadata_in_valid;
    logic [NUM_EGR_PORTS-1:0][DATA_BYTES*8-1:0]      m_axis_tdata;
    logic [NUM_EGR_PORTS-1:0][DATA_BYTES-1:0]        m_axis_tkeep;
    logic [NUM_EGR_PORTS-1:0]                        m_axis_tlast;
    logic [NUM_EGR_PORTS-1:0]                        m_axis_tvalid;
    logic [NUM_EGR_PORTS-1:0]                        m_axis_tready;
    logic [ING_PORT_ID_WIDTH-1:0]                    m_axis_ing_port;

    modport master (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  user_metadata_in, user_metadata_in_valid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        output m_axis_tvalid, m_axis_ing_port
    );

    modport slave (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output user_metadata_in, user_metadata_in_valid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        input  m_axis_tvalid, m_axis_ing_port
    );
endinterface

// File: rtl/p4_router_meta_fifo.sv
// Small synchronous FIFO holding per-packet metadata words. A write while full
// is accepted only when a pop happens in the same cycle.
module p4_router_meta_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp, r_rp;
    logic             w_wr, w_rd;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_rd    = i_rd && !o_empty;
    assign w_wr    = i_wr && (!o_full || w_rd);
    assign o_rdata = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/p4_router_egress_demux.sv
// Steers each VNP4 output packet to the egress port named by its queued egr_spec;
// out-of-range/0xFF packets are drained. Optional P4_ROUTER_EGRESS_DEMUX_STATS_EN adds pkt_count.
module p4_router_egress_demux
    import p4_router_pkg::*;
#(
    parameter int DATA_BYTES        = 8,
    parameter int NUM_EGR_PORTS     = 11,
    parameter int EGR_SPEC_ID_WIDTH = 8,
    parameter int ING_PORT_ID_WIDTH = 8,
    parameter int META_FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        aresetn,
    p4_router_egress_demux_if.master    io,
    output logic [31:0]                 drop_count,
    output logic                        meta_overflow
`ifdef P4_ROUTER_EGRESS_DEMUX_STATS_EN
    ,
    output logic [NUM_EGR_PORTS-1:0][31:0] pkt_count
`endif
);
    localparam int MW = EGR_SPEC_ID_WIDTH + ING_PORT_ID_WIDTH;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                         r_state, w_next;
    logic [EGR_SPEC_ID_WIDTH-1:0]   r_sel;
    logic [ING_PORT_ID_WIDTH-1:0]   r_ing;
    logic [31:0]                    r_drop_cnt;
    logic                           r_meta_ovf;
    logic                           w_pop, w_full, w_empty, w_sready, w_head_fwd;
    logic [MW-1:0]                  w_head;
    logic [EGR_SPEC_ID_WIDTH-1:0]   w_head_egr;
    logic [NUM_EGR_PORTS-1:0]       w_hit;
    logic [DATA_BYTES*8-1:0]        w_data;

    p4_router_meta_fifo #(.WIDTH(MW), .DEPTH(META_FIFO_DEPTH)) u_meta_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .i_wr    (io.user_metadata_in_valid),
        .i_wdata (io.user_metadata_in),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_egr = w_head[MW-1:ING_PORT_ID_WIDTH];
    assign w_head_fwd = (w_head_egr != EGR_SPEC_ID_WIDTH'(EGR_DROP_SENTINEL)) &&
                        (w_head_egr <  EGR_SPEC_ID_WIDTH'(NUM_EGR_PORTS));

    // one-hot port select; comparing per port avoids indexing with a wide egr_spec
    for (genvar g = 0; g < NUM_EGR_PORTS; g++) begin : g_port
        assign w_hit[g] = (r_state == FWD) && (r_sel == EGR_SPEC_ID_WIDTH'(g));
    end

    assign w_data             = io.s_axis_tdata;
    assign io.m_axis_tdata    = {NUM_EGR_PORTS{w_data}};
    assign io.m_axis_tkeep    = {NUM_EGR_PORTS{io.s_axis_tkeep}};
    assign io.m_axis_tlast    = {NUM_EGR_PORTS{io.s_axis_tlast}};
    assign io.m_axis_tvalid   = w_hit & {NUM_EGR_PORTS{io.s_axis_tvalid}};
    assign io.s_axis_tready   = w_sready;
    assign io.m_axis_ing_port = r_ing;
    assign drop_count         = r_drop_cnt;
    assign meta_overflow      = r_meta_ovf;

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_sready = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = w_head_fwd ? FWD : DROP;
                end
            end
            FWD: begin
                w_sready = |(w_hit & io.m_axis_tready);
                if (io.s_axis_tvalid && w_sready && io.s_axis_tlast) w_next = IDLE;
            end
            DROP: begin
                w_sready = 1'b1;
                if (io.s_axis_tvalid && io.s_axis_tlast) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_ing      <= '0;
            r_drop_cnt <= '0;
            r_meta_ovf <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_pop) begin
                r_sel <= w_head_egr;
                r_ing <= w_head[ING_PORT_ID_WIDTH-1:0];
            end
            if (r_state == DROP && io.s_axis_tvalid && io.s_axis_tlast &&
                r_drop_cnt != 32'hFFFF_FFFF)
                r_drop_cnt <= r_drop_cnt + 32'd1;
            if (io.user_metadata_in_valid && w_full && !w_pop)
                r_meta_ovf <= 1'b1;
        end
    end

`ifdef P4_ROUTER_EGRESS_DEMUX_STATS_EN
    for (genvar g = 0; g < NUM_EGR_PORTS; g++) begin : g_stat
        logic [31:0] r_cnt;
        always_ff @(posedge clk or negedge aresetn) begin
            if (!aresetn) r_cnt <= '0;
            else if (io.m_axis_tvalid[g] && io.m_axis_tready[g] && io.s_axis_tlast)
                r_cnt <= r_cnt + 32'd1;
        end
        assign pkt_count[g] = r_cnt;
    end
`endif
endmodule

// File: tb/tb_p4_router_egress_demux.sv
// Directed bench for p4_router_egress_demux: routing, pre-metadata stall, drop,
// metadata overflow, random egress backpressure and mid-packet reset.
module tb_p4_router_egress_demux;
    import p4_router_pkg::*;

    localparam int NP = 11;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] drop_count;
    logic        meta_overflow;
    int          checks = 0;
    int          failures = 0;
`ifdef P4_ROUTER_EGRESS_DEMUX_STATS_EN
    logic [NP-1:0][31:0] pkt_count;
`endif

    p4_router_egress_demux_if #(.DATA_BYTES(8), .NUM_EGR_PORTS(NP),
        .EGR_SPEC_ID_WIDTH(8), .ING_PORT_ID_WIDTH(8)) bus ();

    p4_router_egress_demux #(.DATA_BYTES(8), .NUM_EGR_PORTS(NP), .EGR_SPEC_ID_WIDTH(8),
        .ING_PORT_ID_WIDTH(8), .META_FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .io            (bus),
        .drop_count    (drop_count),
        .meta_overflow (meta_overflow)
`ifdef P4_ROUTER_EGRESS_DEMUX_STATS_EN
        ,
        .pkt_count     (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the strobe edge.
    task automatic send_meta(input logic [7:0] egr, input logic [7:0] ing);
        USER_META_DATA_METADATA_T md;
        md.egr_spec = egr;
        md.ing_port = ing;
        bus.user_metadata_in       = md;
        bus.user_metadata_in_valid = 1'b1;
        @(posedge clk); #1;
        bus.user_metadata_in_valid = 1'b0;
    endtask

    // Offers an n-beat packet (data base+i) and tracks what emerges on 'port'.
    task automatic run_pkt(input string tag, input int port, input int n,
                           input logic [63:0] base, input bit rnd);
        int idx = 0, cyc = 0, got = 0, bad = 0;
        logic [NP-1:0] mask, stray;
        logic hs;
        mask  = (port < NP) ? NP'(1 << port) : '0;
        stray = '0;
        while (idx < n && cyc < 2000) begin
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = base + 64'(idx);
            bus.s_axis_tkeep  = (idx == n - 1) ? 8'h0F : 8'hFF;
            bus.s_axis_tlast  = (idx == n - 1);
            bus.m_axis_tready = rnd ? NP'($urandom) : '1;
            #2;
            stray |= bus.m_axis_tvalid & ~mask;
            if (port < NP && bus.m_axis_tvalid[port] && bus.m_axis_tready[port]) begin
                got++;
                if (bus.m_axis_tdata[port] !== base + 64'(idx) ||
                    bus.m_axis_tkeep[port] !== ((idx == n - 1) ? 8'h0F : 8'hFF) ||
                    bus.m_axis_tlast[port] !== (idx == n - 1))
                    bad++;
            end
            hs = bus.s_axis_tvalid && bus.s_axis_tready;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = '1;
        check({tag, "_beats_accepted"}, 64'(idx), 64'(n));
        check({tag, "_beats_delivered"}, 64'(got), (port < NP) ? 64'(n) : 64'd0);
        check({tag, "_data_order"}, 64'(bad), 64'd0);
        check({tag, "_other_tvalid"}, 64'(stray), 64'd0);
    endtask

    initial begin
        logic early;
        logic [7:0] q_egr [5];
        q_egr = '{8'd2, 8'd4, 8'd6, 8'd9, 8'd8};
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.user_metadata_in       = '0;
        bus.user_metadata_in_valid = 1'b0;
        bus.m_axis_tready = '1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_meta_overflow", 64'(meta_overflow), 64'd0);
        check("rst_ing_port", 64'(bus.m_axis_ing_port), 64'd0);
        aresetn = 1'b1;
        @(posedge clk); #1;
        check("idle_empty_no_ready", 64'(bus.s_axis_tready), 64'd0);

        // basic forward to port 3
        send_meta(8'd3, 8'd1);
        run_pkt("t1", 3, 4, 64'h100, 1'b0);
        check("t1_ing_port", 64'(bus.m_axis_ing_port), 64'd1);
        check("t1_drop_count", 64'(drop_count), 64'd0);

        // data waiting before metadata
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 64'h200;
        bus.s_axis_tkeep  = 8'hFF;
        early = 1'b0;
        repeat (5) begin
            #2 early |= bus.s_axis_tready;
            @(posedge clk); #1;
        end
        check("t2_no_ready_before_meta", 64'(early), 64'd0);
        send_meta(8'd0, 8'd2);
        #2 check("t2_no_ready_pop_cycle", 64'(bus.s_axis_tready), 64'd0);
        @(posedge clk); #1;
        check("t2_ready_after_pop", 64'(bus.s_axis_tready), 64'd1);
        run_pkt("t2", 0, 3, 64'h200, 1'b0);
        check("t2_ing_port", 64'(bus.m_axis_ing_port), 64'd2);

        // drop sentinel, then highest port
        send_meta(8'hFF, 8'd4);
        run_pkt("t3_drop", 255, 3, 64'h300, 1'b0);
        check("t3_drop_count", 64'(drop_count), 64'd1);
        send_meta(8'd10, 8'd5);
        run_pkt("t3_p10", 10, 2, 64'h310, 1'b0);
        check("t3_drop_count_after", 64'(drop_count), 64'd1);

        // FSM parked in FWD on port 1, then 5 strobes into a 4-deep FIFO
        send_meta(8'd1, 8'd7);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            bus.user_metadata_in       = {q_egr[i], 8'(20 + i)};
            bus.user_metadata_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.user_metadata_in_valid = 1'b0;
        check("t4_meta_overflow", 64'(meta_overflow), 64'd1);
        run_pkt("t4_p1", 1, 1, 64'h400, 1'b0);
        run_pkt("t4_p2", 2, 1, 64'h410, 1'b0);
        run_pkt("t4_p4", 4, 2, 64'h420, 1'b0);
        check("t4_ing_p4", 64'(bus.m_axis_ing_port), 64'd21);
        run_pkt("t4_p6", 6, 1, 64'h430, 1'b0);
        run_pkt("t4_p9", 9, 1, 64'h440, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_fifo_drained_no_ready", 64'(bus.s_axis_tready), 64'd0);
        check("t4_overflow_sticky", 64'(meta_overflow), 64'd1);

        // random backpressure on port 5
        send_meta(8'd5, 8'd3);
        run_pkt("t5", 5, 64, 64'h1000, 1'b1);

        // reset during beat 2 of a 6-beat packet to port 6
        send_meta(8'd6, 8'd9);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tkeep  = 8'hFF;
        bus.s_axis_tdata  = 64'h600;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.s_axis_tdata  = 64'h601;
        @(posedge clk); #1;
        bus.s_axis_tdata  = 64'h602;
        #2 check("t6_mid_tvalid", 64'(bus.m_axis_tvalid), 64'(NP'(1 << 6)));
        aresetn = 1'b0;
        #1;
        check("t6_rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("t6_rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        check("t6_rst_drop_count", 64'(drop_count), 64'd0);
        check("t6_rst_overflow", 64'(meta_overflow), 64'd0);
        check("t6_rst_ing_port", 64'(bus.m_axis_ing_port), 64'd0);
        bus.s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(posedge clk); #1;
        send_meta(8'd7, 8'd4);
        run_pkt("t6_after", 7, 2, 64'h700, 1'b0);
        check("t6_after_ing", 64'(bus.m_axis_ing_port), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
